// File: rtl/wb_arbiter_pkg.sv
// Core-wide definitions shared by the decoder, LSU and writeback stage:
// register/word widths, load funct3 encodings and load data extension.
package wb_arbiter_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 1 << REG_AW;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // Pick the addressed byte/half out of the aligned word and extend it to XLEN.
  function automatic logic [XLEN-1:0] extend_load(input logic [2:0]      funct3,
                                                  input logic [1:0]      addr_lo,
                                                  input logic [XLEN-1:0] word);
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] result;
    byte_sel = 8'(word >> {addr_lo, 3'b000});
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
      default: result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback-stage bus: ALU result, LSU load response and register-file write port.
// slave = the arbiter itself; master = the pipeline/LSU/regfile around it.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic                alu_valid_i;
  logic [REG_AW-1:0]   alu_rd_i;
  logic [XLEN-1:0]     alu_data_i;
  logic                alu_stall_o;

  logic                lsu_valid_i;
  logic                lsu_ready_o;
  logic [REG_AW-1:0]   lsu_rd_i;
  logic [2:0]          lsu_funct3_i;
  logic [1:0]          lsu_addr_lo_i;
  logic [XLEN-1:0]     lsu_rdata_i;

  logic                rd_wr_en_o;
  logic [REG_AW-1:0]   rd_addr_o;
  logic [XLEN-1:0]     rd_data_o;
  logic [NUM_REGS-1:0] pending_mask_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    output alu_stall_o,
    input  lsu_valid_i, lsu_rd_i, lsu_funct3_i, lsu_addr_lo_i, lsu_rdata_i,
    output lsu_ready_o,
    output rd_wr_en_o, rd_addr_o, rd_data_o, pending_mask_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    input  alu_stall_o,
    output lsu_valid_i, lsu_rd_i, lsu_funct3_i, lsu_addr_lo_i, lsu_rdata_i,
    input  lsu_ready_o,
    input  rd_wr_en_o, rd_addr_o, rd_data_o, pending_mask_o
  );

endinterface

// File: rtl/wb_load_fifo.sv
// DEPTH-entry circular FIFO of {rd, data} load results, exposing the count and
// a per-slot valid vector plus slot rd fields for pending-mask generation.
module wb_load_fifo
  import wb_arbiter_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  wb_entry_t                    push_entry_i,
  input  logic                         pop_i,
  output wb_entry_t                    head_o,
  output logic [CNT_W-1:0]             count_o,
  output logic [DEPTH-1:0]             valid_o,
  output logic [DEPTH-1:0][REG_AW-1:0] rd_o
);

  wb_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DEPTH-1:0]   valid_q, valid_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (push_i) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (pop_i) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // NOTE: payload storage has no reset; valid_q/count_q alone say which slots mean anything.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) rd_o[i] = mem_q[i].rd;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: owns the register-file write port, merging single-cycle
// ALU results with queued (extended) load responses, with starvation relief.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);

  wb_entry_t                    fifo_head;
  wb_entry_t                    push_entry;
  logic [CNT_W-1:0]             fifo_count;
  logic [DEPTH-1:0]             fifo_valid;
  logic [DEPTH-1:0][REG_AW-1:0] fifo_rd;
  logic                         fifo_empty;
  logic                         lsu_ready;
  logic                         push;
  logic                         pop;
  logic                         starve;
  logic                         alu_write;
  logic [NUM_REGS-1:0]          pending_mask;

  logic                         wr_en_q, wr_en_d;
  logic [REG_AW-1:0]            addr_q, addr_d;
  logic [XLEN-1:0]              data_q, data_d;
  logic [SC_W-1:0]              starve_cnt_q, starve_cnt_d;

  wb_load_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (fifo_head),
    .count_o      (fifo_count),
    .valid_o      (fifo_valid),
    .rd_o         (fifo_rd)
  );

  // Loads to x0 are acknowledged but never queued, so they never write or mark pending.
  assign fifo_empty = (fifo_count == '0);
  assign lsu_ready  = (fifo_count != CNT_W'(DEPTH));
  assign push       = bus.lsu_valid_i && lsu_ready && (bus.lsu_rd_i != '0);
  assign push_entry = '{rd:   bus.lsu_rd_i,
                        data: extend_load(bus.lsu_funct3_i, bus.lsu_addr_lo_i, bus.lsu_rdata_i)};

  assign starve    = !fifo_empty && (starve_cnt_q == SC_W'(STARVE_LIMIT - 1));
  assign alu_write = bus.alu_valid_i && (bus.alu_rd_i != '0) && !starve;
  assign pop       = !fifo_empty && !alu_write;

  always_comb begin
    wr_en_d      = alu_write || pop;
    addr_d       = addr_q;
    data_d       = data_q;
    starve_cnt_d = (fifo_empty || pop) ? '0 : starve_cnt_q + SC_W'(1);
    if (alu_write) begin
      addr_d = bus.alu_rd_i;
      data_d = bus.alu_data_i;
    end else if (pop) begin
      addr_d = fifo_head.rd;
      data_d = fifo_head.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      starve_cnt_q <= '0;
    end else begin
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i]) pending_mask[fifo_rd[i]] = 1'b1;
    end
  end

  assign bus.alu_stall_o    = starve;
  assign bus.lsu_ready_o    = lsu_ready;
  assign bus.rd_wr_en_o     = wr_en_q;
  assign bus.rd_addr_o      = addr_q;
  assign bus.rd_data_o      = data_q;
  assign bus.pending_mask_o = pending_mask;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts every
// register-file write cycle; a negedge monitor pops and compares the prediction.
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_arbiter_if bus();

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {logic [4:0] rd; logic [31:0] data;} ld_t;
  typedef struct {logic en; logic [4:0] addr; logic [31:0] data;} wr_t;

  ld_t         mq[$];
  wr_t         exp_q[$];
  int          denied;
  logic [4:0]  last_addr;
  logic [31:0] last_data;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic        a_valid = 0;
  logic [4:0]  a_rd = 0;
  logic [31:0] a_data = 0;
  logic        l_valid = 0;
  logic [4:0]  l_rd = 0;
  logic [2:0]  l_f3 = 0;
  logic [1:0]  l_off = 0;
  logic [31:0] l_data = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Load result from the architectural definition of each load type.
  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    int unsigned b, h, hs;
    hs = off[1] ? 16 : 0;
    b  = (w >> (8 * off)) & 32'hFF;
    h  = (w >> hs) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("wr_en", bus.rd_wr_en_o, e.en);
      check("wr_addr", bus.rd_addr_o, e.addr);
      check("wr_data", bus.rd_data_o, e.data);
    end
  end

  // One clock cycle: drive, check combinational outputs, predict the write, advance the model.
  task automatic step(output bit alu_taken, output bit lsu_taken);
    bit          nonempty, starve, alu_write, pop, ready;
    logic [31:0] mask;
    wr_t         e;
    bus.alu_valid_i   = a_valid;
    bus.alu_rd_i      = a_rd;
    bus.alu_data_i    = a_data;
    bus.lsu_valid_i   = l_valid;
    bus.lsu_rd_i      = l_rd;
    bus.lsu_funct3_i  = l_f3;
    bus.lsu_addr_lo_i = l_off;
    bus.lsu_rdata_i   = l_data;
    #1;
    nonempty = (mq.size() != 0);
    ready    = (mq.size() < DEPTH);
    starve   = nonempty && (denied == LIMIT - 1);
    mask     = '0;
    foreach (mq[i]) mask[mq[i].rd] = 1'b1;
    check("alu_stall", bus.alu_stall_o, starve);
    check("lsu_ready", bus.lsu_ready_o, ready);
    check("pending_mask", bus.pending_mask_o, mask);

    alu_write = a_valid && (a_rd != 0) && !starve;
    pop       = nonempty && !alu_write;
    alu_taken = a_valid && !starve;
    lsu_taken = l_valid && ready;

    if (alu_write) begin
      e = '{1'b1, a_rd, a_data};
    end else if (pop) begin
      e = '{1'b1, mq[0].rd, mq[0].data};
    end else begin
      e = '{1'b0, last_addr, last_data};
    end
    last_addr = e.addr;
    last_data = e.data;
    exp_q.push_back(e);

    if (pop) begin
      void'(mq.pop_front());
      denied = 0;
    end else if (nonempty) begin
      denied++;
    end else begin
      denied = 0;
    end
    if (lsu_taken && l_rd != 0) mq.push_back('{l_rd, m_ext(l_f3, l_off, l_data)});
    @(negedge clk);
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [31:0] data);
    a_valid = 1'b1; a_rd = rd; a_data = data;
  endtask

  task automatic set_lsu(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] data);
    l_valid = 1'b1; l_rd = rd; l_f3 = f3; l_off = off; l_data = data;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    mq.delete();
    denied    = 0;
    last_addr = '0;
    last_data = '0;
    a_valid   = 1'b0;
    l_valid   = 1'b0;
    bus.alu_valid_i = 1'b0;
    bus.lsu_valid_i = 1'b0;
    #2;
    check("rst_wr_en", bus.rd_wr_en_o, 1'b0);
    check("rst_mask", bus.pending_mask_o, 32'h0);
    @(negedge clk);
    check("rst_wr_en_held", bus.rd_wr_en_o, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_ready", bus.lsu_ready_o, 1'b1);
    check("rst_stall", bus.alu_stall_o, 1'b0);
  endtask

  initial begin
    bit          at, lt;
    logic [31:0] held;
    int          budget;

    bus.alu_valid_i = 1'b0; bus.alu_rd_i = '0; bus.alu_data_i = '0;
    bus.lsu_valid_i = 1'b0; bus.lsu_rd_i = '0; bus.lsu_funct3_i = '0;
    bus.lsu_addr_lo_i = '0; bus.lsu_rdata_i = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // Load extension: LB from byte 3, then LHU from the upper half.
    set_lsu(5'd5, 3'b000, 2'd3, 32'h80FF_0000);
    step(at, lt);
    l_valid = 1'b0;
    step(at, lt);
    check("lb_en", bus.rd_wr_en_o, 1'b1);
    check("lb_addr", bus.rd_addr_o, 32'd5);
    check("lb_data", bus.rd_data_o, 32'hFFFF_FF80);
    set_lsu(5'd6, 3'b101, 2'd2, 32'h8001_1234);
    step(at, lt);
    l_valid = 1'b0;
    step(at, lt);
    check("lhu_addr", bus.rd_addr_o, 32'd6);
    check("lhu_data", bus.rd_data_o, 32'h0000_8001);

    // ALU priority over a queued load.
    set_alu(5'd3, 32'hAAAA_0001);
    set_lsu(5'd7, 3'b010, 2'd0, 32'hCAFE_F00D);
    step(at, lt);
    l_valid = 1'b0;
    check("prio_addr0", bus.rd_addr_o, 32'd3);
    check("prio_mask0", bus.pending_mask_o[7], 1'b1);
    set_alu(5'd3, 32'hAAAA_0002);
    step(at, lt);
    a_valid = 1'b0;
    check("prio_data1", bus.rd_data_o, 32'hAAAA_0002);
    check("prio_mask1", bus.pending_mask_o[7], 1'b1);
    step(at, lt);
    check("prio_load_addr", bus.rd_addr_o, 32'd7);
    check("prio_load_data", bus.rd_data_o, 32'hCAFE_F00D);
    check("prio_mask_clr", bus.pending_mask_o[7], 1'b0);

    // FIFO full under continuous ALU traffic; the 5th load waits.
    do_reset();
    at = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (at) set_alu(5'd1, $urandom);
      set_lsu(5'(10 + i), 3'b010, 2'd0, $urandom);
      step(at, lt);
    end
    check("full_not_ready", bus.lsu_ready_o, 1'b0);
    set_lsu(5'd14, 3'b010, 2'd0, 32'h1414_1414);
    lt     = 1'b0;
    budget = 40;
    while (!lt && budget > 0) begin
      if (at) set_alu(5'd1, $urandom);
      step(at, lt);
      budget--;
    end
    check("full_5th_accepted", lt, 1'b1);
    l_valid = 1'b0;
    a_valid = 1'b0;
    repeat (DEPTH + 2) step(at, lt);
    check("full_drained_mask", bus.pending_mask_o, 32'h0);

    // Starvation: one queued load, ALU valid every cycle.
    do_reset();
    set_alu(5'd3, $urandom);
    set_lsu(5'd9, 3'b010, 2'd0, 32'h1234_5678);
    step(at, lt);
    l_valid = 1'b0;
    for (int k = 1; k < LIMIT; k++) begin
      check("starve_no_stall", bus.alu_stall_o, 1'b0);
      set_alu(5'd3, $urandom);
      step(at, lt);
    end
    check("starve_stall", bus.alu_stall_o, 1'b1);
    held = a_data;
    step(at, lt);
    check("starve_load_addr", bus.rd_addr_o, 32'd9);
    check("starve_load_data", bus.rd_data_o, 32'h1234_5678);
    step(at, lt);
    a_valid = 1'b0;
    check("starve_alu_addr", bus.rd_addr_o, 32'd3);
    check("starve_alu_data", bus.rd_data_o, held);

    // rd=0 handling for both sources.
    do_reset();
    set_lsu(5'd0, 3'b010, 2'd0, $urandom);
    step(at, lt);
    l_valid = 1'b0;
    check("x0_load_mask", bus.pending_mask_o, 32'h0);
    step(at, lt);
    check("x0_load_no_write", bus.rd_wr_en_o, 1'b0);
    set_alu(5'd2, $urandom);
    set_lsu(5'd4, 3'b010, 2'd0, 32'h4444_0004);
    step(at, lt);
    l_valid = 1'b0;
    set_alu(5'd0, $urandom);
    step(at, lt);
    a_valid = 1'b0;
    check("x0_alu_pop_addr", bus.rd_addr_o, 32'd4);
    check("x0_alu_pop_data", bus.rd_data_o, 32'h4444_0004);

    // Reset with two loads queued.
    set_alu(5'd1, $urandom);
    set_lsu(5'd20, 3'b010, 2'd0, $urandom);
    step(at, lt);
    set_alu(5'd1, $urandom);
    set_lsu(5'd21, 3'b010, 2'd0, $urandom);
    step(at, lt);
    check("midq_mask", bus.pending_mask_o, 32'h0030_0000);
    do_reset();

    // Randomised traffic: moderate then heavy ALU load.
    at = 1'b1;
    lt = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int alu_pct, lsu_pct;
      alu_pct = (cyc < 2000) ? 60 : 95;
      lsu_pct = (cyc < 2000) ? 50 : 30;
      if (at || !a_valid) begin
        a_valid = ($urandom_range(99) < alu_pct);
        a_rd    = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
        a_data  = $urandom;
      end
      if (lt || !l_valid) begin
        l_valid = ($urandom_range(99) < lsu_pct);
        l_rd    = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
        l_f3    = 3'($urandom_range(7));
        l_off   = 2'($urandom_range(3));
        l_data  = $urandom;
      end
      step(at, lt);
    end
    a_valid = 1'b0;
    l_valid = 1'b0;
    repeat (DEPTH + 2) step(at, lt);
    check("final_mask", bus.pending_mask_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
